// File: rtl/pe_xnor_responder_pkg.sv
// Shared definitions for the PE datapath and its controller: FSM states,
// default widths and the saturating accumulator add.
package pe_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int ACC_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAITMEM = 3'd1,
    ST_PCNT1   = 3'd2,
    ST_PCNT2   = 3'd3,
    ST_HOLD    = 3'd4
  } pe_state_e;

  // Symmetric saturation to +/-(2^(w-1)-1); operands are sign-extended w-bit values (w <= 31)
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] x,
                                                 input logic signed [31:0] y,
                                                 input int unsigned        w);
    logic signed [31:0] s;
    logic signed [31:0] lim;
    s   = x + y;
    lim = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    if (s > lim) begin
      return lim;
    end else if (s < -lim) begin
      return -lim;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/pe_xnor_responder_if.sv
// Command/done handshake and memory port between the PE controller and the
// XNOR responder.
interface pe_xnor_responder_if import pe_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = 8
) ();

  logic                     isRead;
  logic                     isCount;
  logic                     continuePcnt;
  logic                     addPcnts;
  logic                     continueAcc;
  logic                     binarizeStart;
  logic                     finish;
  logic signed [ACC_W-1:0]  threshold;
  logic                     mem_req;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_valid;
  logic [WORD_W-1:0]        mem_w;
  logic [WORD_W-1:0]        mem_a;
  logic                     readyToPick;
  logic                     readDone;
  logic                     pcntDone;
  logic                     accDone;
  logic                     finishAll;
  logic                     out_bit;
  logic                     out_valid;
  logic                     cmd_err;

  modport slave (
    input  isRead, isCount, continuePcnt, addPcnts, continueAcc, binarizeStart, finish,
    input  threshold, mem_valid, mem_w, mem_a,
    output mem_req, mem_addr, readyToPick, readDone, pcntDone, accDone,
    output finishAll, out_bit, out_valid, cmd_err
  );

  modport master (
    output isRead, isCount, continuePcnt, addPcnts, continueAcc, binarizeStart, finish,
    output threshold, mem_valid, mem_w, mem_a,
    input  mem_req, mem_addr, readyToPick, readDone, pcntDone, accDone,
    input  finishAll, out_bit, out_valid, cmd_err
  );

endinterface

// File: rtl/pe_xnor_responder_popcount2.sv
// Two-stage XNOR popcount: stage 1 counts each half word, stage 2 adds the halves.
module pe_popcount2 #(
  parameter int WORD_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load1_i,
  input  logic                         load2_i,
  input  logic [WORD_W-1:0]            w_i,
  input  logic [WORD_W-1:0]            a_i,
  output logic [$clog2(WORD_W+1)-1:0]  pcnt_o
);

  localparam int HALF = WORD_W / 2;
  localparam int HC_W = $clog2(HALF + 1);
  localparam int PC_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] xn_s;
  logic [HC_W-1:0]   lo_q;
  logic [HC_W-1:0]   hi_q;
  logic [PC_W-1:0]   pcnt_q;

  function automatic logic [HC_W-1:0] count_ones(input logic [HALF-1:0] v);
    logic [HC_W-1:0] n;
    n = {HC_W{1'b0}};
    for (int i = 0; i < HALF; i++) begin
      n = n + HC_W'(v[i]);
    end
    return n;
  endfunction

  assign xn_s   = ~(w_i ^ a_i);
  assign pcnt_o = pcnt_q;

  // Half-word counts on load1, their sum on load2; results hold until reloaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= {HC_W{1'b0}};
      hi_q   <= {HC_W{1'b0}};
      pcnt_q <= {PC_W{1'b0}};
    end else begin
      if (load1_i) begin
        lo_q <= count_ones(xn_s[HALF-1:0]);
        hi_q <= count_ones(xn_s[WORD_W-1:HALF]);
      end
      if (load2_i) begin
        pcnt_q <= PC_W'(lo_q) + PC_W'(hi_q);
      end
    end
  end

endmodule

// File: rtl/pe_xnor_responder.sv
// Binary-neuron datapath responder: fetches word pairs, XNOR-popcounts them,
// accumulates the +/-1 dot product and binarizes against a threshold.
module pe_xnor_responder import pe_pkg::*; #(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int NUM_WORDS   = 8,
  parameter int NUM_NEURONS = 4,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int ADDR_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  pe_xnor_responder_if.slave bus
);

  localparam int WI_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int NI_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int PC_W = $clog2(WORD_W + 1);

  pe_state_e               state_q, state_d;
  logic [WI_W-1:0]         word_idx_q, word_idx_d;
  logic [NI_W-1:0]         neuron_idx_q, neuron_idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0]       w_q, w_d, a_q, a_d;
  logic                    held_q, held_d, pvalid_q, pvalid_d;
  logic                    fin_q, fin_d, err_q, err_d, out_bit_q, out_bit_d;
  logic                    mem_req_q, mem_req_d, rdy_q, rdy_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic                    read_done_q, read_done_d, pcnt_done_q, pcnt_done_d;
  logic                    acc_done_q, acc_done_d, out_valid_q, out_valid_d;

  logic                    ld1_s, ld2_s, any_cmd_s, ge_s, word_last_s, neuron_last_s;
  logic [PC_W-1:0]         pcnt_s;
  logic signed [31:0]      term_s, acc_next_s;
  logic [ADDR_W-1:0]       addr_s;
  logic                    unused_is_count_s;

  pe_popcount2 #(.WORD_W(WORD_W)) u_popcount (
    .clk     (clk),
    .rst_n   (rst),
    .load1_i (ld1_s),
    .load2_i (ld2_s),
    .w_i     (w_q),
    .a_i     (a_q),
    .pcnt_o  (pcnt_s)
  );

  assign unused_is_count_s = bus.isCount;
  assign any_cmd_s     = bus.isRead | bus.continuePcnt | bus.addPcnts | bus.binarizeStart | bus.finish;
  assign term_s        = 2 * $signed(32'(pcnt_s)) - WORD_W;
  assign acc_next_s    = bus.continueAcc ? sat_add(32'(acc_q), term_s, ACC_W)
                                         : sat_add(32'sd0, term_s, ACC_W);
  assign ge_s          = $signed(acc_q) >= $signed(bus.threshold);
  assign word_last_s   = (word_idx_q == WI_W'(NUM_WORDS - 1));
  assign neuron_last_s = (neuron_idx_q == NI_W'(NUM_NEURONS - 1));
  assign addr_s        = ADDR_W'(neuron_idx_q) * ADDR_W'(NUM_WORDS) + ADDR_W'(word_idx_q);

  // Command decode and next-state; only one command is honoured per cycle
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    neuron_idx_d = neuron_idx_q;
    acc_d        = acc_q;
    w_d          = w_q;
    a_d          = a_q;
    held_d       = held_q;
    pvalid_d     = pvalid_q;
    fin_d        = fin_q;
    err_d        = err_q;
    out_bit_d    = out_bit_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = 1'b0;
    read_done_d  = 1'b0;
    pcnt_done_d  = 1'b0;
    acc_done_d   = 1'b0;
    out_valid_d  = 1'b0;
    ld1_s        = 1'b0;
    ld2_s        = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (bus.finish) begin
          word_idx_d   = {WI_W{1'b0}};
          neuron_idx_d = {NI_W{1'b0}};
          acc_d        = {ACC_W{1'b0}};
          fin_d        = 1'b0;
          err_d        = 1'b0;
          held_d       = 1'b0;
          pvalid_d     = 1'b0;
          state_d      = ST_IDLE;
        end else if (bus.binarizeStart) begin
          out_bit_d   = ge_s;
          out_valid_d = 1'b1;
          acc_d       = {ACC_W{1'b0}};
          if (neuron_last_s) begin
            neuron_idx_d = {NI_W{1'b0}};
            fin_d        = 1'b1;
          end else begin
            neuron_idx_d = neuron_idx_q + NI_W'(1);
          end
        end else if (bus.addPcnts) begin
          if (pvalid_q) begin
            acc_d    = ACC_W'(acc_next_s);
            held_d   = 1'b0;
            pvalid_d = 1'b0;
            state_d  = ST_IDLE;
            if (word_last_s) begin
              word_idx_d = {WI_W{1'b0}};
              acc_done_d = 1'b1;
            end else begin
              word_idx_d = word_idx_q + WI_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.continuePcnt) begin
          if (held_q) begin
            ld1_s    = 1'b1;
            pvalid_d = 1'b0;
            state_d  = ST_PCNT1;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.isRead) begin
          mem_req_d  = 1'b1;
          mem_addr_d = addr_s;
          state_d    = ST_WAITMEM;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAITMEM: begin
        if (any_cmd_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (bus.mem_valid) begin
          w_d         = bus.mem_w;
          a_d         = bus.mem_a;
          held_d      = 1'b1;
          pvalid_d    = 1'b0;
          read_done_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          state_d = ST_WAITMEM;
        end
      end
      ST_PCNT1: begin
        if (any_cmd_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        ld2_s       = 1'b1;
        pvalid_d    = 1'b1;
        pcnt_done_d = 1'b1;
        state_d     = ST_PCNT2;
      end
      ST_PCNT2: begin
        if (any_cmd_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        state_d = ST_HOLD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d = (state_d == ST_IDLE) && !held_d;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_idx_q   <= {WI_W{1'b0}};
      neuron_idx_q <= {NI_W{1'b0}};
      acc_q        <= {ACC_W{1'b0}};
      w_q          <= {WORD_W{1'b0}};
      a_q          <= {WORD_W{1'b0}};
      held_q       <= 1'b0;
      pvalid_q     <= 1'b0;
      fin_q        <= 1'b0;
      err_q        <= 1'b0;
      out_bit_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      rdy_q        <= 1'b1;
      read_done_q  <= 1'b0;
      pcnt_done_q  <= 1'b0;
      acc_done_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      neuron_idx_q <= neuron_idx_d;
      acc_q        <= acc_d;
      w_q          <= w_d;
      a_q          <= a_d;
      held_q       <= held_d;
      pvalid_q     <= pvalid_d;
      fin_q        <= fin_d;
      err_q        <= err_d;
      out_bit_q    <= out_bit_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      rdy_q        <= rdy_d;
      read_done_q  <= read_done_d;
      pcnt_done_q  <= pcnt_done_d;
      acc_done_q   <= acc_done_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.readyToPick = rdy_q;
  assign bus.readDone    = read_done_q;
  assign bus.pcntDone    = pcnt_done_q;
  assign bus.accDone     = acc_done_q;
  assign bus.finishAll   = fin_q;
  assign bus.out_bit     = out_bit_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.cmd_err     = err_q;

endmodule
